// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port register file.
package regfile_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } clr_state_t;

   localparam int DEF_DATA_WIDTH = 20;
   localparam int DEF_REG_NUMBER = 5;
   localparam int DEF_NUM_READ   = 3;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: array lookup, x0 forced to zero, optional same-cycle write forwarding.
module regfile_read_port
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int REG_NUMBER = DEF_REG_NUMBER
)
(
   input  logic [REG_NUMBER-1:0]   i_addr,
   input  logic [DATA_WIDTH-1:0]   i_regs [2**REG_NUMBER],
   input  logic [2**REG_NUMBER-1:0] i_busy,
   input  logic                    i_bypass_en,
   input  logic [1:0]              i_wr_en,
   input  logic [2*REG_NUMBER-1:0] i_wr_addr,
   input  logic [2*DATA_WIDTH-1:0] i_wr_data,
   input  logic                    i_rsv_en,
   input  logic [REG_NUMBER-1:0]   i_rsv_addr,
   output logic [DATA_WIDTH-1:0]   o_data,
   output logic                    o_busy
);

   logic w_hit0;
   logic w_hit1;
   logic w_rsv_hit;

   assign w_hit0    = i_bypass_en && i_wr_en[0] && (i_wr_addr[REG_NUMBER-1:0] == i_addr);
   assign w_hit1    = i_bypass_en && i_wr_en[1] && (i_wr_addr[2*REG_NUMBER-1:REG_NUMBER] == i_addr);
   assign w_rsv_hit = i_rsv_en && (i_rsv_addr == i_addr);

   // A forwarded write is about to clear busy, so only a same-cycle reserve keeps it set.
   always_comb begin
      o_data = i_regs[i_addr];
      o_busy = i_busy[i_addr];
      if (i_addr == '0) begin
         o_data = '0;
         o_busy = 1'b0;
      end else if (w_hit1) begin
         o_data = i_wr_data[2*DATA_WIDTH-1:DATA_WIDTH];
         o_busy = w_rsv_hit;
      end else if (w_hit0) begin
         o_data = i_wr_data[DATA_WIDTH-1:0];
         o_busy = w_rsv_hit;
      end
   end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with busy scoreboard and a sequential clear sweep.
// Optional feature: define REG_FILE_BYPASS_EN to forward same-cycle writes to the read ports.
module register_file_mp
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int REG_NUMBER = DEF_REG_NUMBER,
   parameter int NUM_READ   = DEF_NUM_READ
)
(
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_READ*REG_NUMBER-1:0] rs_addr,
   output logic [NUM_READ*DATA_WIDTH-1:0] rs_data,
   output logic [NUM_READ-1:0]            rs_busy,
   input  logic [1:0]                     wr_en,
   input  logic [2*REG_NUMBER-1:0]        wr_addr,
   input  logic [2*DATA_WIDTH-1:0]        wr_data,
   input  logic                           rsv_en,
   input  logic [REG_NUMBER-1:0]          rsv_addr,
   input  logic                           clr_req,
   output logic                           clr_busy
);

   localparam int DEPTH = 2**REG_NUMBER;

   logic [DATA_WIDTH-1:0] r_regs [DEPTH];
   logic [DEPTH-1:0]      r_busy;
   clr_state_t            r_state;
   logic [REG_NUMBER-1:0] r_index;
   logic                  r_clr_busy;

   logic [REG_NUMBER-1:0] w_wr_addr [2];
   logic [DATA_WIDTH-1:0] w_wr_data [2];
   logic                  w_bypass_en;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_wr
         assign w_wr_addr[gi] = wr_addr[gi*REG_NUMBER +: REG_NUMBER];
         assign w_wr_data[gi] = wr_data[gi*DATA_WIDTH +: DATA_WIDTH];
      end
   endgenerate

`ifdef REG_FILE_BYPASS_EN
   assign w_bypass_en = (r_state == IDLE);
`else
   assign w_bypass_en = 1'b0;
`endif

   // Port 1 is applied after port 0 and the reserve after both, giving the required priorities.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_regs[i] <= '0;
         end
         r_busy     <= '0;
         r_state    <= IDLE;
         r_index    <= '0;
         r_clr_busy <= 1'b0;
      end else if (r_state == SWEEP) begin
         r_regs[r_index] <= '0;
         r_busy[r_index] <= 1'b0;
         r_index         <= r_index + 1'b1;
         if (r_index == '1) begin
            r_state    <= IDLE;
            r_clr_busy <= 1'b0;
         end
      end else begin
         for (int p = 0; p < 2; p++) begin
            if (wr_en[p] && (w_wr_addr[p] != '0)) begin
               r_regs[w_wr_addr[p]] <= w_wr_data[p];
               r_busy[w_wr_addr[p]] <= 1'b0;
            end
         end
         if (rsv_en && (rsv_addr != '0)) begin
            r_busy[rsv_addr] <= 1'b1;
         end
         if (clr_req) begin
            r_state    <= SWEEP;
            r_index    <= REG_NUMBER'(1);
            r_clr_busy <= 1'b1;
         end
      end
   end

   assign clr_busy = r_clr_busy;

   generate
      for (gi = 0; gi < NUM_READ; gi++) begin : g_rd
         regfile_read_port #(
            .DATA_WIDTH (DATA_WIDTH),
            .REG_NUMBER (REG_NUMBER)
         ) u_read_port (
            .i_addr      (rs_addr[gi*REG_NUMBER +: REG_NUMBER]),
            .i_regs      (r_regs),
            .i_busy      (r_busy),
            .i_bypass_en (w_bypass_en),
            .i_wr_en     (wr_en),
            .i_wr_addr   (wr_addr),
            .i_wr_data   (wr_data),
            .i_rsv_en    (rsv_en),
            .i_rsv_addr  (rsv_addr),
            .o_data      (rs_data[gi*DATA_WIDTH +: DATA_WIDTH]),
            .o_busy      (rs_busy[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: directed vector table, hand-written sweep/reset sequences, random run against a model.
module tb_register_file_mp;

   localparam int DW = 20;
   localparam int RN = 5;
   localparam int NR = 3;
   localparam int NREG = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic [NR*RN-1:0]  rs_addr;
   logic [NR*DW-1:0]  rs_data;
   logic [NR-1:0]     rs_busy;
   logic [1:0]        wr_en;
   logic [2*RN-1:0]   wr_addr;
   logic [2*DW-1:0]   wr_data;
   logic              rsv_en;
   logic [RN-1:0]     rsv_addr;
   logic              clr_req;
   logic              clr_busy;

   // Stimulus variables, driven after the falling edge.
   logic              t_rst;
   logic [1:0]        t_we;
   logic [RN-1:0]     t_wa0, t_wa1;
   logic [DW-1:0]     t_wd0, t_wd1;
   logic              t_rsv;
   logic [RN-1:0]     t_rsva;
   logic              t_clr;
   logic [RN-1:0]     t_rs [NR];

   // Outputs sampled mid-cycle by tick().
   logic [DW-1:0]     s_data [NR];
   logic              s_busy [NR];
   logic              s_clr_busy;

   // Reference model of the architectural state.
   logic [DW-1:0]     m_regs [NREG];
   bit                m_busy [NREG];
   bit                m_sweep;
   int                m_idx;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   assign rst      = t_rst;
   assign rs_addr  = {t_rs[2], t_rs[1], t_rs[0]};
   assign wr_en    = t_we;
   assign wr_addr  = {t_wa1, t_wa0};
   assign wr_data  = {t_wd1, t_wd0};
   assign rsv_en   = t_rsv;
   assign rsv_addr = t_rsva;
   assign clr_req  = t_clr;

   register_file_mp #(.DATA_WIDTH(DW), .REG_NUMBER(RN), .NUM_READ(NR)) dut (
      .clk      (clk),
      .rst      (rst),
      .rs_addr  (rs_addr),
      .rs_data  (rs_data),
      .rs_busy  (rs_busy),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr),
      .clr_req  (clr_req),
      .clr_busy (clr_busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic clear_inputs();
      t_rst = 1'b0; t_we = 2'b00; t_wa0 = '0; t_wa1 = '0; t_wd0 = '0; t_wd1 = '0;
      t_rsv = 1'b0; t_rsva = '0; t_clr = 1'b0;
      for (int k = 0; k < NR; k++) t_rs[k] = '0;
   endtask

   function automatic logic [DW-1:0] exp_data(input logic [RN-1:0] a);
      if (a == 0) return '0;
`ifdef REG_FILE_BYPASS_EN
      if (!m_sweep) begin
         if (t_we[1] && t_wa1 == a) return t_wd1;
         if (t_we[0] && t_wa0 == a) return t_wd0;
      end
`endif
      return m_regs[a];
   endfunction

   function automatic logic exp_busy(input logic [RN-1:0] a);
      if (a == 0) return 1'b0;
`ifdef REG_FILE_BYPASS_EN
      if (!m_sweep && ((t_we[1] && t_wa1 == a) || (t_we[0] && t_wa0 == a)))
         return t_rsv && (t_rsva == a);
`endif
      return m_busy[a];
   endfunction

   task automatic model_edge();
      if (t_rst) begin
         for (int i = 0; i < NREG; i++) begin m_regs[i] = '0; m_busy[i] = 0; end
         m_sweep = 0;
         m_idx = 0;
      end else if (m_sweep) begin
         m_regs[m_idx] = '0;
         m_busy[m_idx] = 0;
         if (m_idx == NREG - 1) m_sweep = 0;
         else m_idx++;
      end else begin
         if (t_we[0] && t_wa0 != 0) begin m_regs[t_wa0] = t_wd0; m_busy[t_wa0] = 0; end
         if (t_we[1] && t_wa1 != 0) begin m_regs[t_wa1] = t_wd1; m_busy[t_wa1] = 0; end
         if (t_rsv && t_rsva != 0) m_busy[t_rsva] = 1;
         if (t_clr) begin m_sweep = 1; m_idx = 1; end
      end
   endtask

   // One transaction: inputs already set after a falling edge; sample, step model, clear inputs.
   task automatic tick(input bit use_model);
      #2;
      for (int k = 0; k < NR; k++) begin
         s_data[k] = rs_data[k*DW +: DW];
         s_busy[k] = rs_busy[k];
      end
      s_clr_busy = clr_busy;
      if (use_model) begin
         for (int k = 0; k < NR; k++) begin
            chk($sformatf("model_data[%0d]", k), 32'(s_data[k]), 32'(exp_data(t_rs[k])));
            chk($sformatf("model_busy[%0d]", k), 32'(s_busy[k]), 32'(exp_busy(t_rs[k])));
         end
         chk("model_clr_busy", 32'(s_clr_busy), 32'(m_sweep));
      end
      $display("[tb] cyc=%0d rst=%b we=%b wa=%0d/%0d rsv=%b:%0d clr=%b rs=%0d/%0d/%0d data=%h/%h/%h cbusy=%b",
               cyc, t_rst, t_we, t_wa0, t_wa1, t_rsv, t_rsva, t_clr, t_rs[0], t_rs[1], t_rs[2],
               s_data[0], s_data[1], s_data[2], s_clr_busy);
      @(posedge clk);
      model_edge();
      cyc++;
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic load_all();
      for (int i = 1; i < NREG; i += 2) begin
         t_we = 2'b01; t_wa0 = RN'(i); t_wd0 = DW'(20'h01000 + i * 20'h00111);
         if (i + 1 < NREG) begin
            t_we[1] = 1'b1; t_wa1 = RN'(i + 1); t_wd1 = DW'(20'h01000 + (i + 1) * 20'h00111);
         end
         t_rsv = (i == 9 || i == 21); t_rsva = RN'(i);
         t_rs[0] = RN'(i); t_rs[1] = RN'(i + 1); t_rs[2] = RN'(i - 1);
         tick(1);
      end
   endtask

   task automatic read_all_zero(input string tag);
      for (int b = 0; b < NREG; b += NR) begin
         for (int k = 0; k < NR; k++) t_rs[k] = RN'((b + k) % NREG);
         tick(1);
         for (int k = 0; k < NR; k++) begin
            chk($sformatf("%s_data_x%0d", tag, (b + k) % NREG), 32'(s_data[k]), 32'h0);
            chk($sformatf("%s_busy_x%0d", tag, (b + k) % NREG), 32'(s_busy[k]), 32'h0);
         end
      end
   endtask

   typedef struct {
      logic [1:0]    we;
      logic [RN-1:0] wa0, wa1;
      logic [DW-1:0] wd0, wd1;
      logic          rsv;
      logic [RN-1:0] rsva;
      logic [RN-1:0] ra0, ra1, ra2;
      logic [DW-1:0] ed0, ed1, ed2;
      logic          eb0, eb1, eb2;
   } vec_t;

   vec_t vecs [10];

   initial begin
      int cnt;
      vecs[0] = '{2'b11, 5'd3, 5'd2, 20'h00011, 20'h0002A, 1'b0, 5'd0, 5'd1, 5'd0, 5'd4, 20'h0, 20'h0, 20'h0, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{2'b00, 5'd0, 5'd0, 20'h0, 20'h0, 1'b0, 5'd0, 5'd3, 5'd2, 5'd0, 20'h00011, 20'h0002A, 20'h0, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{2'b01, 5'd4, 5'd0, 20'h0003B, 20'h0, 1'b0, 5'd0, 5'd3, 5'd2, 5'd1, 20'h00011, 20'h0002A, 20'h0, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{2'b11, 5'd5, 5'd5, 20'h00AAA, 20'h00BBB, 1'b0, 5'd0, 5'd4, 5'd0, 5'd1, 20'h0003B, 20'h0, 20'h0, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{2'b01, 5'd0, 5'd0, 20'hFFFFF, 20'h0, 1'b1, 5'd7, 5'd5, 5'd0, 5'd7, 20'h00BBB, 20'h0, 20'h0, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{2'b00, 5'd0, 5'd0, 20'h0, 20'h0, 1'b0, 5'd0, 5'd7, 5'd0, 5'd5, 20'h0, 20'h0, 20'h00BBB, 1'b1, 1'b0, 1'b0};
      vecs[6] = '{2'b01, 5'd7, 5'd0, 20'h00999, 20'h0, 1'b1, 5'd7, 5'd0, 5'd4, 5'd3, 20'h0, 20'h0003B, 20'h00011, 1'b0, 1'b0, 1'b0};
      vecs[7] = '{2'b00, 5'd0, 5'd0, 20'h0, 20'h0, 1'b0, 5'd0, 5'd7, 5'd2, 5'd0, 20'h00999, 20'h0002A, 20'h0, 1'b1, 1'b0, 1'b0};
      vecs[8] = '{2'b10, 5'd0, 5'd7, 20'h0, 20'h00123, 1'b0, 5'd0, 5'd5, 5'd4, 5'd3, 20'h00BBB, 20'h0003B, 20'h00011, 1'b0, 1'b0, 1'b0};
      vecs[9] = '{2'b00, 5'd0, 5'd0, 20'h0, 20'h0, 1'b0, 5'd0, 5'd7, 5'd0, 5'd1, 20'h00123, 20'h0, 20'h0, 1'b0, 1'b0, 1'b0};

      for (int i = 0; i < NREG; i++) begin m_regs[i] = '0; m_busy[i] = 0; end
      m_sweep = 0;
      m_idx = 0;
      clear_inputs();
      @(negedge clk);

      // Reset, then every address on every port reads zero and not busy.
      t_rst = 1'b1; tick(0);
      t_rst = 1'b1; tick(0);
      tick(1);
      chk("reset_clr_busy", 32'(s_clr_busy), 32'h0);
      read_all_zero("reset");

      // Directed table: writes, dual-port collision, x0 discard, scoreboard priorities.
      for (int v = 0; v < 10; v++) begin
         t_we = vecs[v].we; t_wa0 = vecs[v].wa0; t_wa1 = vecs[v].wa1;
         t_wd0 = vecs[v].wd0; t_wd1 = vecs[v].wd1;
         t_rsv = vecs[v].rsv; t_rsva = vecs[v].rsva;
         t_rs[0] = vecs[v].ra0; t_rs[1] = vecs[v].ra1; t_rs[2] = vecs[v].ra2;
         tick(0);
         chk($sformatf("vec%0d_data0", v), 32'(s_data[0]), 32'(vecs[v].ed0));
         chk($sformatf("vec%0d_data1", v), 32'(s_data[1]), 32'(vecs[v].ed1));
         chk($sformatf("vec%0d_data2", v), 32'(s_data[2]), 32'(vecs[v].ed2));
         chk($sformatf("vec%0d_busy0", v), 32'(s_busy[0]), 32'(vecs[v].eb0));
         chk($sformatf("vec%0d_busy1", v), 32'(s_busy[1]), 32'(vecs[v].eb1));
         chk($sformatf("vec%0d_busy2", v), 32'(s_busy[2]), 32'(vecs[v].eb2));
         chk($sformatf("vec%0d_clr_busy", v), 32'(s_clr_busy), 32'h0);
      end

      // Same-cycle read of a register being written.
      t_we = 2'b01; t_wa0 = 5'd6; t_wd0 = 20'h00055; t_rs[0] = 5'd6;
      tick(0);
`ifdef REG_FILE_BYPASS_EN
      chk("bypass_same_cycle", 32'(s_data[0]), 32'h00055);
`else
      chk("no_bypass_same_cycle", 32'(s_data[0]), 32'h0);
`endif
      t_rs[0] = 5'd6;
      tick(0);
      chk("x6_next_cycle", 32'(s_data[0]), 32'h00055);

      // Full sweep: 31 busy cycles, mid-sweep write to x9 ignored, everything zero afterwards.
      load_all();
      t_clr = 1'b1; tick(1);
      cnt = 0;
      for (int c = 0; c < 100; c++) begin
         if (c == 1) begin
            t_we = 2'b01; t_wa0 = 5'd9; t_wd0 = 20'hABCDE; t_rsv = 1'b1; t_rsva = 5'd9; t_clr = 1'b1;
         end
         t_rs[0] = 5'd9;
         tick(1);
         if (!s_clr_busy) break;
         cnt++;
      end
      chk("sweep_length", 32'(cnt), 32'd31);
      read_all_zero("sweep");

      // Sweep aborted by reset on its 10th cycle.
      load_all();
      t_clr = 1'b1; tick(1);
      for (int c = 0; c < 10; c++) begin
         t_rst = (c == 9);
         t_rs[0] = 5'd31;
         tick(1);
         chk($sformatf("abort_sweep_busy_c%0d", c), 32'(s_clr_busy), 32'h1);
      end
      tick(1);
      chk("abort_idle_after_rst", 32'(s_clr_busy), 32'h0);
      read_all_zero("abort");

      // Randomized traffic against the model.
      for (int r = 0; r < 600; r++) begin
         bit narrow;
         narrow = ($urandom_range(0, 1) == 1);
         t_we  = 2'($urandom);
         t_wa0 = narrow ? RN'($urandom_range(0, 7)) : RN'($urandom);
         t_wa1 = narrow ? RN'($urandom_range(0, 7)) : RN'($urandom);
         t_wd0 = DW'($urandom);
         t_wd1 = DW'($urandom);
         t_rsv = ($urandom_range(0, 9) < 3);
         t_rsva = narrow ? RN'($urandom_range(0, 7)) : RN'($urandom);
         t_clr = ($urandom_range(0, 99) < 2);
         t_rst = ($urandom_range(0, 199) == 0);
         for (int k = 0; k < NR; k++) t_rs[k] = narrow ? RN'($urandom_range(0, 7)) : RN'($urandom);
         tick(1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/register_file_mp.md
REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 20, giving the register data width in bits.
REQ-002 The block SHALL have parameter REG_NUMBER, default 5, giving the address width; there are 2**REG_NUMBER registers.
REQ-003 The block SHALL have parameter NUM_READ, default 3, giving the number of read ports.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 rs_addr  in  NUM_READ*REG_NUMBER  packed read addresses; port k uses slice k.
REQ-007 rs_data  out  NUM_READ*DATA_WIDTH  packed read data.
REQ-008 rs_busy  out  NUM_READ  scoreboard busy bit of each read address.
REQ-009 wr_en  in  2  write enables for write ports 0 and 1.
REQ-010 wr_addr  in  2*REG_NUMBER  write addresses.
REQ-011 wr_data  in  2*DATA_WIDTH  write data.
REQ-012 rsv_en / rsv_addr  in  1 / REG_NUMBER  scoreboard reserve request.
REQ-013 clr_req  in  1  starts a full-array clear sweep.
REQ-014 clr_busy  out  1  high while a sweep is in progress.

Function
REQ-015 Reads SHALL be combinational from the array; address 0 SHALL always read 0.
REQ-016 Writes SHALL take effect at the rising edge with wr_en[p]=1; writes to address 0 SHALL be discarded.
REQ-017 Both write ports to the same nonzero address in one cycle: port 1 data SHALL be stored.
REQ-018 Scoreboard: rsv_en=1 SHALL set busy[rsv_addr] at the edge; any accepted write SHALL clear busy[wr_addr].
REQ-019 Reserve and write to the same address in one cycle: busy SHALL end set (the reserve wins).
REQ-020 busy[0] SHALL be constant 0; rs_busy[k] = busy[rs_addr slice k], combinational.
REQ-021 Clear FSM has states IDLE and SWEEP.
  - IDLE with clr_req=1 goes to SWEEP with index=1.
  - Each SWEEP cycle zeroes reg[index] and busy[index], then increments index.
  - After index 2**REG_NUMBER-1, the FSM returns to IDLE.
  - A sweep therefore takes 2**REG_NUMBER-1 cycles.
REQ-022 In SWEEP, clr_busy=1, wr_en and rsv_en SHALL be ignored, clr_req SHALL be ignored, and reads SHALL return current array contents.
REQ-023 In IDLE, clr_busy=0.

Reset
REQ-024 rst=1 at an edge SHALL zero all registers and busy bits, force IDLE, and set index=0 and clr_busy=0.
REQ-025 rst SHALL take priority over writes, reserves and an in-progress sweep; the sweep is aborted.

Configuration
REQ-026 With macro REG_FILE_BYPASS_EN defined:
  - A read whose address matches an active nonzero write in the same cycle SHALL return the write data (port 1 over port 0).
  - The forwarded read's rs_busy SHALL read 0 unless rsv_en targets the same address.
  - Bypass SHALL be inactive during SWEEP.
REQ-027 Without REG_FILE_BYPASS_EN, reads SHALL return the pre-edge stored value; new data is visible the cycle after the write.

Structure
REQ-028 A shared package regfile_pkg SHALL hold the FSM state enum (IDLE, SWEEP) and the default width constants.
REQ-029 The N-port read mux plus bypass SHALL be one sub-module, regfile_read_port, instantiated NUM_READ times.

Verification
REQ-030 Reset and sweep all addresses on all read ports -> every rs_data=0 and rs_busy=0.
REQ-031 Write x3=0x00011 and x2=0x0002A, read x3/x2 next cycle -> 0x00011/0x0002A; write x4=sum -> x4 reads 0x0003B.
REQ-032 Both ports write x5 (0x00AAA on port 0, 0x00BBB on port 1) -> x5 reads 0x00BBB; a write of 0xFFFFF to x0 -> x0 reads 0.
REQ-033 Reserve x7 -> rs_busy=1; reserve and write x7 in the same cycle -> stays 1; later write x7=0x00123 -> busy 0 and data 0x00123.
REQ-034 Load x1..x31 nonzero, then pulse clr_req:
  - clr_busy is high for exactly 31 cycles.
  - A write to x9 mid-sweep is ignored.
  - All registers read 0 afterward.
  - Repeat with rst asserted at cycle 10 -> IDLE next cycle and all registers 0.
REQ-035 With REG_FILE_BYPASS_EN, write x6=0x00055 while reading x6 -> rs_data=0x00055 in the same cycle; without the macro, rs_data holds the old value that cycle.
